mac_dot_sequencer: RTL and testbench

MAC_DOT_SEQUENCER -- requirements
Module: mac_dot_sequencer

---
 rtl/mac_dot_sequencer.sv | 157 +++++++++++++++
 tb/tb_mac_dot_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_sequencer.sv
// Sequences operand pairs through a small FIFO into an external MAC and captures the dot product.
// Define MAC_SEQ_STALL_CNT_EN to build the saturating RUN-stall counter.
module mac_dot_sequencer #(
    parameter int N     = 32,
    parameter int LEN_W = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     g_in,
    input  logic [N-1:0]     e_in,
    output logic [N-1:0]     mac_g,
    output logic [N-1:0]     mac_e,
    output logic             mac_clr,
    input  logic [N-1:0]     mac_o,
    output logic [N-1:0]     result,
    output logic             done,
    output logic             busy,
    output logic [15:0]      stall_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] accepted_q;
    logic [LEN_W-1:0] issued_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [N-1:0]     g_mem [DEPTH];
    logic [N-1:0]     e_mem [DEPTH];
    logic             push;
    logic             pop;
    logic             last_pop;

    assign in_ready = (state_q == RUN) && (accepted_q < len_q)
                   && (count_q != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    // Occupancy is the registered count, so a pair pushed this cycle cannot pop until next.
    assign pop      = (state_q == RUN) && (count_q != '0) && (issued_q < len_q);
    assign last_pop = pop && ((issued_q + LEN_W'(1)) == len_q);

    assign mac_clr = (state_q == CLEAR);
    assign done    = (state_q == DONE);
    assign busy    = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CLEAR;
            CLEAR:   state_d = (len_q == '0) ? DRAIN : RUN;
            RUN:     if (last_pop) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q <= '0;
        end else if (state_q == IDLE && start) begin
            len_q <= len;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            accepted_q <= '0;
            issued_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else if (state_q == CLEAR) begin
            accepted_q <= '0;
            issued_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            if (push) begin
                accepted_q <= accepted_q + LEN_W'(1);
                wr_ptr_q   <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                issued_q <= issued_q + LEN_W'(1);
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            g_mem[wr_ptr_q] <= g_in;
            e_mem[wr_ptr_q] <= e_in;
        end
    end

    // Zero operands on idle cycles keep the downstream accumulator unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mac_g <= '0;
            mac_e <= '0;
        end else if (pop) begin
            mac_g <= g_mem[rd_ptr_q];
            mac_e <= e_mem[rd_ptr_q];
        end else begin
            mac_g <= '0;
            mac_e <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  result <= '0;
        else if (state_q == DRAIN) result <= mac_o;
    end

`ifdef MAC_SEQ_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (state_q == CLEAR) begin
            stall_q <= '0;
        end else if (state_q == RUN && !pop && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Randomized bench for mac_dot_sequencer with a behavioural MAC and a sum-of-products reference.
// Stall expectations follow MAC_SEQ_STALL_CNT_EN when defined.
module tb_mac_dot_sequencer;
    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  len_i;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] g_in;
    logic [31:0] e_in;
    logic [31:0] mac_g;
    logic [31:0] mac_e;
    logic        mac_clr;
    logic [31:0] mac_o;
    logic [31:0] result;
    logic        done;
    logic        busy;
    logic [15:0] stall_cnt;

    logic [31:0] acc;
    logic [31:0] gq [64];
    logic [31:0] eq [64];
    int n_chk;
    int n_err;

    mac_dot_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .g_in      (g_in),
        .e_in      (e_in),
        .mac_g     (mac_g),
        .mac_e     (mac_e),
        .mac_clr   (mac_clr),
        .mac_o     (mac_o),
        .result    (result),
        .done      (done),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External MAC: accumulator plus current product.
    assign mac_o = acc + mac_g * mac_e;

    always @(posedge clk or negedge rst) begin
        if (!rst)         acc <= '0;
        else if (mac_clr) acc <= '0;
        else              acc <= mac_o;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".mac_g"}, mac_g, 0);
        chk({tag, ".mac_e"}, mac_e, 0);
        chk({tag, ".mac_clr"}, mac_clr, 0);
        chk({tag, ".result"}, result, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".in_ready"}, in_ready, 0);
        chk({tag, ".stall_cnt"}, stall_cnt, 0);
    endtask

    // mode: 0 back-to-back, 1 toggled valid, 2 random valid.
    task automatic run_job(input string name, input int l, input int mode,
                           input int repulse_c);
        logic [31:0] exp_r;
        int idx, dcnt, clr_n, rdy_n, clr_c, done_c, c, run_c;
        exp_r = '0;
        idx = 0; dcnt = 0; clr_n = 0; rdy_n = 0;
        clr_c = -1; done_c = -1; c = 0;
        for (int i = 0; i < l; i++) exp_r = exp_r + gq[i] * eq[i];
        while (c < 400 && (done_c < 0 || c <= done_c + 2)) begin
            start = (c == 0) || (c == repulse_c);
            len_i = (c == 0) ? 8'(l) : 8'd7;
            case (mode)
                0:       in_valid = (idx < l);
                1:       in_valid = (idx < l) && (c % 2 == 1);
                default: in_valid = (idx < l) && ($urandom_range(0, 1) == 1);
            endcase
            g_in = gq[idx];
            e_in = eq[idx];
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            if (mac_clr) begin
                clr_n++;
                clr_c = c;
            end
            if (in_ready) rdy_n++;
            if (done) begin
                dcnt++;
                if (done_c < 0) done_c = c;
            end
            if (done_c >= 0 && c == done_c + 1)
                chk({name, ".busy_after"}, busy, 0);
            @(posedge clk);
            #1;
            c++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        chk({name, ".done_seen"}, done_c >= 0, 1);
        chk({name, ".done_count"}, dcnt, 1);
        chk({name, ".result"}, result, exp_r);
        chk({name, ".clr_count"}, clr_n, 1);
        chk({name, ".accepted"}, idx, l);
        if (l == 0) begin
            chk({name, ".ready_len0"}, rdy_n, 0);
            chk({name, ".done_lat"}, done_c, 3);
        end
        run_c = done_c - clr_c - 2;
`ifdef MAC_SEQ_STALL_CNT_EN
        chk({name, ".stall"}, stall_cnt, run_c - l);
        if (mode == 1 && l > 1) chk({name, ".stall_pos"}, stall_cnt > 0, 1);
`else
        chk({name, ".stall"}, stall_cnt, 0);
`endif
    endtask

    initial begin
        int l;
        int idx;
        bit reached;
        n_chk = 0;
        n_err = 0;
        rst = 1'b0;
        start = 1'b0;
        len_i = '0;
        in_valid = 1'b0;
        g_in = '0;
        e_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        gq[0] = 1; eq[0] = 2; gq[1] = 3; eq[1] = 4;
        gq[2] = 5; eq[2] = 6; gq[3] = 7; eq[3] = 8;
        run_job("b2b4", 4, 0, -1);

        run_job("len0", 0, 0, -1);

        for (int i = 0; i < 3; i++) begin
            gq[i] = 2;
            eq[i] = 5;
        end
        run_job("toggle3", 3, 1, -1);

        gq[0] = 32'hFFFF_FFFF; eq[0] = 2;
        run_job("wrap", 1, 0, -1);

        gq[0] = 4; eq[0] = 4; gq[1] = 1; eq[1] = 1;
        run_job("restart", 2, 1, 3);

        // Abort after two accepted pairs of a four-pair job.
        for (int i = 0; i < 4; i++) begin
            gq[i] = 32'(i + 3);
            eq[i] = 32'(i + 5);
        end
        idx = 0;
        reached = 1'b0;
        start = 1'b1;
        len_i = 8'd4;
        for (int c = 0; c < 50 && !reached; c++) begin
            in_valid = (idx < 4);
            g_in = gq[idx];
            e_in = eq[idx];
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            if (idx == 2) reached = 1'b1;
            else begin
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        chk("abort.feed", reached, 1);
        #1;
        rst = 1'b0;
        #1;
        start = 1'b0;
        in_valid = 1'b0;
        chk_zero("abort");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort.no_done", done, 0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        gq[0] = 3; eq[0] = 3;
        run_job("after_abort", 1, 0, -1);

        for (int j = 0; j < 6; j++) begin
            l = $urandom_range(0, 12);
            for (int i = 0; i < l; i++) begin
                gq[i] = $urandom;
                eq[i] = $urandom;
            end
            run_job($sformatf("rand%0d", j), l, 2, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
